// File: rtl/pwm_bank_if.sv
// Bus bundle for pwm_bank: control/staging inputs from the host side and the
// registered PWM outputs and status back to it.
interface pwm_bank_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
);

  logic                      enable;
  logic                      load;
  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic                      center;
  logic [CHANNELS-1:0]       pwm;
  logic                      frame_start;
  logic                      pending;

  modport master (
    output enable,
    output load,
    output period,
    output duty,
    output center,
    input  pwm,
    input  frame_start,
    input  pending
  );

  modport slave (
    input  enable,
    input  load,
    input  period,
    input  duty,
    input  center,
    output pwm,
    output frame_start,
    output pending
  );

endinterface

// File: rtl/pwm_bank.sv
// Multi-channel PWM generator. All channels share one period counter that runs
// either edge-aligned (0..period, wrap) or center-aligned (up 0..period-1, then
// down period-1..0). Period, duty and mode are double-buffered: a load stages
// them in shadow registers, and they reach the active registers only at a frame
// boundary (or right away while idle), so a frame never changes shape midway.
module pwm_bank #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 8
) (
  input logic       clk,
  input logic       reset_n,
  pwm_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  typedef logic [CHANNELS-1:0][WIDTH-1:0] duty_vec_t;

  dir_t                dir_q, dir_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]    period_a_q, period_a_d;
  duty_vec_t           duty_a_q, duty_a_d;
  logic                center_a_q, center_a_d;

  logic [WIDTH-1:0]    period_s_q, period_s_d;
  duty_vec_t           duty_s_q, duty_s_d;
  logic                center_s_q, center_s_d;

  logic                pending_q, pending_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                frame_start_q, frame_start_d;

  duty_vec_t           duty_in;
  logic                boundary;
  logic                last_up;

  assign duty_in = bus.duty;

  // Detect the last counter value of the frame and the top of the up-ramp.
  always_comb begin
    boundary = 1'b0;
    last_up  = 1'b0;
    if (period_a_q == '0) begin
      boundary = 1'b1;
    end else if (center_a_q) begin
      boundary = (dir_q == DIR_DOWN) && (cnt_q == '0);
      last_up  = (dir_q == DIR_UP) && (cnt_q == (period_a_q - CNT_ONE));
    end else begin
      boundary = (cnt_q == period_a_q);
    end
  end

  // Counter and direction: hold at 0/up while idle, restart at every boundary.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!bus.enable || boundary) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (!center_a_q) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      case (dir_q)
        DIR_UP: begin
          if (last_up) begin
            dir_d = DIR_DOWN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        DIR_DOWN: begin
          cnt_d = cnt_q - CNT_ONE;
        end
      endcase
    end
  end

  // Shadow staging and transfer into the active set; a load on the boundary
  // goes straight to the active set so it is not delayed by a whole frame.
  always_comb begin
    period_s_d = period_s_q;
    duty_s_d   = duty_s_q;
    center_s_d = center_s_q;
    period_a_d = period_a_q;
    duty_a_d   = duty_a_q;
    center_a_d = center_a_q;
    pending_d  = pending_q;

    if (bus.load) begin
      period_s_d = bus.period;
      duty_s_d   = duty_in;
      center_s_d = bus.center;
      pending_d  = 1'b1;
    end

    if (bus.enable && boundary) begin
      if (bus.load) begin
        period_a_d = bus.period;
        duty_a_d   = duty_in;
        center_a_d = bus.center;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        period_a_d = period_s_q;
        duty_a_d   = duty_s_q;
        center_a_d = center_s_q;
        pending_d  = 1'b0;
      end
    end else if (!bus.enable && pending_q) begin
      period_a_d = period_s_q;
      duty_a_d   = duty_s_q;
      center_a_d = center_s_q;
      if (!bus.load) begin
        pending_d = 1'b0;
      end
    end
  end

  // Compare each channel against the shared counter; silent while idle.
  always_comb begin
    pwm_d         = '0;
    frame_start_d = 1'b0;
    if (bus.enable) begin
      for (int i = 0; i < CHANNELS; i++) begin
        pwm_d[i] = (cnt_q < duty_a_q[i]);
      end
      frame_start_d = (cnt_q == '0) && (dir_q == DIR_UP);
    end
  end

  // State register with synchronous active-low reset clearing everything.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dir_q         <= DIR_UP;
      cnt_q         <= '0;
      period_a_q    <= '0;
      duty_a_q      <= '0;
      center_a_q    <= 1'b0;
      period_s_q    <= '0;
      duty_s_q      <= '0;
      center_s_q    <= 1'b0;
      pending_q     <= 1'b0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      dir_q         <= dir_d;
      cnt_q         <= cnt_d;
      period_a_q    <= period_a_d;
      duty_a_q      <= duty_a_d;
      center_a_q    <= center_a_d;
      period_s_q    <= period_s_d;
      duty_s_q      <= duty_s_d;
      center_s_q    <= center_s_d;
      pending_q     <= pending_d;
      pwm_q         <= pwm_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.pwm         = pwm_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pending     = pending_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: table of configurations measured frame by
// frame against a queue of expected frames, plus hand-written sequences for
// mid-frame loads, boundary loads, back-to-back loads, reset and enable drop.
module tb_pwm_bank;

  localparam int CHANNELS = 4;
  localparam int WIDTH    = 8;

  typedef logic [WIDTH-1:0] word_t;

  typedef struct packed {
    logic [WIDTH-1:0]               period;
    logic [CHANNELS-1:0][WIDTH-1:0] duty;
    logic                           center;
    logic [31:0]                    len;
    logic [CHANNELS-1:0][15:0]      highs;
  } frame_exp_t;

  logic clk = 1'b0;
  logic reset_n;

  int n_compared   = 0;
  int n_mismatched = 0;

  frame_exp_t exp_q [$];
  frame_exp_t tbl [7];

  pwm_bank_if #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) bus ();

  pwm_bank #(.CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Hard time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int exp_len(input word_t p, input logic c);
    if (p == 0) return 1;
    if (c) return 2 * int'(p);
    return int'(p) + 1;
  endfunction

  function automatic int exp_high(input word_t p, input word_t d, input logic c);
    if (p == 0) return (d != 0) ? 1 : 0;
    if (c) return (d >= p) ? 2 * int'(p) : 2 * int'(d);
    return (d > p) ? int'(p) + 1 : int'(d);
  endfunction

  // Expected level of a channel at output cycle j of a frame.
  function automatic logic golden(input word_t p, input word_t d, input logic c, input int j);
    if (p == 0) return (d != 0);
    if (c) begin
      if (d >= p) return 1'b1;
      return (j < int'(d)) || (j >= 2 * int'(p) - int'(d));
    end
    return (j < int'(d));
  endfunction

  function automatic frame_exp_t mk_row(input word_t p, input word_t d0, input word_t d1,
                                        input word_t d2, input word_t d3, input logic c,
                                        input int len, input int h0, input int h1,
                                        input int h2, input int h3);
    frame_exp_t r;
    r.period   = p;
    r.duty[0]  = d0;
    r.duty[1]  = d1;
    r.duty[2]  = d2;
    r.duty[3]  = d3;
    r.center   = c;
    r.len      = len;
    r.highs[0] = 16'(h0);
    r.highs[1] = 16'(h1);
    r.highs[2] = 16'(h2);
    r.highs[3] = 16'(h3);
    return r;
  endfunction

  function automatic frame_exp_t mk_exp(input word_t p, input word_t d0, input word_t d1,
                                        input word_t d2, input word_t d3, input logic c);
    return mk_row(p, d0, d1, d2, d3, c, exp_len(p, c),
                  exp_high(p, d0, c), exp_high(p, d1, c),
                  exp_high(p, d2, c), exp_high(p, d3, c));
  endfunction

  task automatic drive_cfg(input frame_exp_t cfg);
    bus.period = cfg.period;
    bus.duty   = cfg.duty;
    bus.center = cfg.center;
    bus.load   = 1'b1;
  endtask

  // Load a configuration while idle, then enable and land on the first frame.
  task automatic apply_stimulus(input frame_exp_t cfg);
    bus.enable = 1'b0;
    step();
    check("idle_pwm", 32'(bus.pwm), 32'd0);
    check("idle_frame_start", 32'(bus.frame_start), 32'd0);
    drive_cfg(cfg);
    step();
    bus.load = 1'b0;
    check("idle_pending_set", 32'(bus.pending), 32'd1);
    step();
    check("idle_pending_applied", 32'(bus.pending), 32'd0);
    bus.enable = 1'b1;
    step();
    check("first_frame_start", 32'(bus.frame_start), 32'd1);
  endtask

  // Measure one frame starting at a frame_start cycle and score it against the
  // next expected frame; optionally strobe load(s) at a given output cycle.
  task automatic check_output(input int load_at, input frame_exp_t ld,
                              input bit double_load, input bit exp_pend);
    frame_exp_t e;
    frame_exp_t decoy;
    int len;
    int gold_err;
    int highs [CHANNELS];
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    decoy = ld;
    decoy.duty[0] = ld.duty[0] ^ 8'h55;
    for (int ch = 0; ch < CHANNELS; ch++) highs[ch] = 0;
    len = 0;
    gold_err = 0;
    check("frame_align", 32'(bus.frame_start), 32'd1);
    check("pending_at_frame_start", 32'(bus.pending), 32'd0);
    do begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        highs[ch] += int'(bus.pwm[ch]);
        if (bus.pwm[ch] !== golden(e.period, e.duty[ch], e.center, len)) gold_err++;
      end
      if (double_load && len == load_at - 2) drive_cfg(decoy);
      else if (len == load_at) drive_cfg(ld);
      step();
      bus.load = 1'b0;
      if (len == load_at) check("pending_after_load", 32'(bus.pending), 32'(exp_pend));
      len++;
    end while (!bus.frame_start && len < 1000);
    check("frame_len", 32'(len), e.len);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      check($sformatf("high_count_ch%0d", ch), 32'(highs[ch]), 32'(e.highs[ch]));
    end
    check("golden_bit_errors", 32'(gold_err), 32'd0);
  endtask

  initial begin
    frame_exp_t base, cfg_a, cfg_b, cfg_c, none;

    tbl[0] = mk_row(8'd255, 8'd127, 8'd0, 8'd255, 8'd200, 1'b0, 256, 127, 0, 255, 200);
    tbl[1] = mk_row(8'd10,  8'd3,   8'd10, 8'd0,  8'd12,  1'b1, 20,  6,   20, 0,  20);
    tbl[2] = mk_row(8'd0,   8'd1,   8'd0, 8'd255, 8'd0,   1'b0, 1,   1,   0,  1,  0);
    tbl[3] = mk_row(8'd0,   8'd0,   8'd1, 8'd0,   8'd2,   1'b1, 1,   0,   1,  0,  1);
    tbl[4] = mk_row(8'd5,   8'd6,   8'd5, 8'd1,   8'd0,   1'b0, 6,   6,   5,  1,  0);
    tbl[5] = mk_row(8'd1,   8'd1,   8'd0, 8'd2,   8'd0,   1'b1, 2,   2,   0,  2,  0);
    tbl[6] = mk_row(8'd200, 8'd0,   8'd199, 8'd1, 8'd100, 1'b1, 400, 0,   398, 2, 200);

    base  = tbl[0];
    cfg_a = mk_exp(8'd255, 8'd64, 8'd0, 8'd255, 8'd200, 1'b0);
    cfg_b = mk_exp(8'd255, 8'd10, 8'd0, 8'd255, 8'd200, 1'b0);
    cfg_c = mk_exp(8'd255, 8'd90, 8'd0, 8'd255, 8'd200, 1'b0);
    none  = base;

    reset_n    = 1'b0;
    bus.enable = 1'b1;
    bus.load   = 1'b1;
    bus.period = 8'd9;
    bus.duty   = '1;
    bus.center = 1'b0;
    step();
    step();
    bus.load   = 1'b0;
    bus.enable = 1'b0;
    check("reset_pwm", 32'(bus.pwm), 32'd0);
    check("reset_frame_start", 32'(bus.frame_start), 32'd0);
    check("reset_pending", 32'(bus.pending), 32'd0);
    reset_n = 1'b1;

    $display("[TB] table-driven configurations");
    for (int v = 0; v < 7; v++) begin
      apply_stimulus(tbl[v]);
      exp_q.push_back(tbl[v]);
      exp_q.push_back(tbl[v]);
      check_output(-1, none, 1'b0, 1'b0);
      check_output(-1, none, 1'b0, 1'b0);
    end

    $display("[TB] mid-frame load at cnt=50");
    apply_stimulus(base);
    exp_q.push_back(base);
    exp_q.push_back(cfg_a);
    check_output(49, cfg_a, 1'b0, 1'b1);
    check_output(-1, none, 1'b0, 1'b0);

    $display("[TB] load on the boundary cycle");
    exp_q.push_back(cfg_a);
    exp_q.push_back(cfg_b);
    check_output(254, cfg_b, 1'b0, 1'b0);
    check_output(-1, none, 1'b0, 1'b0);

    $display("[TB] back-to-back loads within one frame");
    exp_q.push_back(cfg_b);
    exp_q.push_back(cfg_c);
    check_output(100, cfg_c, 1'b1, 1'b1);
    check_output(-1, none, 1'b0, 1'b0);

    $display("[TB] reset at cnt=100 with a pending load");
    for (int j = 0; j < 100; j++) begin
      if (j == 10) drive_cfg(cfg_b);
      if (j == 99) reset_n = 1'b0;
      step();
      bus.load = 1'b0;
      if (j == 10) check("pending_before_reset", 32'(bus.pending), 32'd1);
    end
    check("midreset_pwm", 32'(bus.pwm), 32'd0);
    check("midreset_frame_start", 32'(bus.frame_start), 32'd0);
    check("midreset_pending", 32'(bus.pending), 32'd0);
    reset_n = 1'b1;

    $display("[TB] enable dropped mid-frame, then re-enabled");
    apply_stimulus(base);
    for (int j = 0; j < 29; j++) step();
    check("running_pwm", 32'(bus.pwm), 32'b1101);
    bus.enable = 1'b0;
    step();
    check("disabled_pwm", 32'(bus.pwm), 32'd0);
    check("disabled_frame_start", 32'(bus.frame_start), 32'd0);
    step();
    step();
    step();
    bus.enable = 1'b1;
    step();
    check("reenable_frame_start", 32'(bus.frame_start), 32'd1);
    exp_q.push_back(base);
    check_output(-1, none, 1'b0, 1'b0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
